// File: rtl/awg_pkg.sv
// Shared constants, fade-state enum and DAC code conversion for the waveform output path.
package awg_pkg;

  localparam int unsigned DAC_W = 14;
  localparam logic [DAC_W-1:0] MIDSCALE = 14'd8192;
  localparam logic [DAC_W-1:0] DAC_MAX = 14'd16383;

  typedef enum logic [1:0] {
    IDLE,
    FADE_IN,
    RUN,
    FADE_OUT
  } fade_state_e;

  // Offset-binary <-> two's complement is an MSB flip; the same function works both ways.
  function automatic logic [DAC_W-1:0] ob_to_tc(input logic [DAC_W-1:0] ob);
    return {~ob[DAC_W-1], ob[DAC_W-2:0]};
  endfunction

endpackage

// File: rtl/gain_ramp.sv
// Soft-mute gain ramp: fade FSM, ramp step counter, saturating gain register and busy flag.
module gain_ramp
  import awg_pkg::*;
#(
  parameter int unsigned RAMP_DIV = 64,
  parameter int unsigned GAIN_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [GAIN_W:0]   gain,
  output logic              busy
);

  localparam int unsigned RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [GAIN_W:0] GAIN_MAX = {1'b1, {GAIN_W{1'b0}}};
  localparam logic [RW-1:0] RCNT_LAST = RW'(RAMP_DIV - 1);

  fade_state_e     state_q, state_d;
  logic [GAIN_W:0] gain_q, gain_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic            busy_q, busy_d;
  logic            step;

  assign step = (rcnt_q == RCNT_LAST);

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    rcnt_d  = step ? '0 : rcnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        gain_d = '0;
        if (en) state_d = FADE_IN;
      end
      FADE_IN: begin
        // A reversal keeps the current gain so the fade turns around without a jump.
        if (!en) begin
          state_d = FADE_OUT;
        end else if (step) begin
          if (gain_q >= GAIN_MAX - 1'b1) begin
            gain_d  = GAIN_MAX;
            state_d = RUN;
          end else begin
            gain_d = gain_q + 1'b1;
          end
        end
      end
      RUN: begin
        gain_d = GAIN_MAX;
        if (!en) state_d = FADE_OUT;
      end
      FADE_OUT: begin
        if (en) begin
          state_d = FADE_IN;
        end else if (step) begin
          if (gain_q <= 1) begin
            gain_d  = '0;
            state_d = IDLE;
          end else begin
            gain_d = gain_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) rcnt_d = '0;
    busy_d = (state_d == FADE_IN) || (state_d == FADE_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gain_q  <= '0;
      rcnt_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      rcnt_q  <= rcnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gain = gain_q;
  assign busy = busy_q;

endmodule

// File: rtl/dac_out_drv.sv
// Dual-channel DAC output stage: soft-mute gain, clamp, and re-timing onto a divided DAC clock.
// Define DAC_TWOS_COMP_EN to emit two's-complement codes instead of offset-binary.
module dac_out_drv #(
  parameter int unsigned SAMPLE_DIV = 2,
  parameter int unsigned RAMP_DIV   = 64,
  parameter int unsigned GAIN_W     = 8,
  parameter int unsigned MIDSCALE   = 8192
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [awg_pkg::DAC_W-1:0]  din_a,
  input  logic [awg_pkg::DAC_W-1:0]  din_b,
  output logic [awg_pkg::DAC_W-1:0]  DA_A,
  output logic [awg_pkg::DAC_W-1:0]  DA_B,
  output logic                       DA_CLK,
  output logic                       busy
);

  import awg_pkg::*;

  localparam int unsigned SCNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SAMPLE_DIV - 1);
  localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(SAMPLE_DIV / 2);
  localparam int unsigned PW = 15 + GAIN_W + 2;
  localparam logic [DAC_W-1:0] MID_OB = DAC_W'(MIDSCALE);

  logic [SCNT_W-1:0]        scnt_q, scnt_d;
  logic                     da_clk_q, da_clk_d;
  logic                     strobe;
  logic [GAIN_W:0]          gain;

  logic [DAC_W-1:0]         din_arr [2];
  logic signed [14:0]       d_q [2];
  logic signed [14:0]       d_d [2];
  logic signed [PW-1:0]     prod [2];
  logic signed [15:0]       p_q [2];
  logic signed [15:0]       p_d [2];
  logic signed [16:0]       sum [2];
  logic [DAC_W-1:0]         clamp [2];
  logic [DAC_W-1:0]         da_q [2];
  logic [DAC_W-1:0]         da_d [2];

  gain_ramp #(
    .RAMP_DIV (RAMP_DIV),
    .GAIN_W   (GAIN_W)
  ) u_gain_ramp (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .gain  (gain),
    .busy  (busy)
  );

  assign din_arr[0] = din_a;
  assign din_arr[1] = din_b;

  // DA_CLK lags scnt by a cycle, so data loaded on the strobe edge sits half a sample
  // period ahead of the DAC's rising-edge latch.
  assign strobe   = (scnt_q == '0);
  assign scnt_d   = (scnt_q == SCNT_LAST) ? '0 : scnt_q + 1'b1;
  assign da_clk_d = (scnt_q >= SCNT_HALF);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      d_d[i]  = $signed({1'b0, din_arr[i]}) - $signed({1'b0, MID_OB});
      prod[i] = $signed({{(PW-15){d_q[i][14]}}, d_q[i]}) *
                $signed({{(PW-GAIN_W-1){1'b0}}, gain});
      p_d[i]  = 16'(prod[i] >>> GAIN_W);
      sum[i]  = $signed({p_q[i][15], p_q[i]}) + $signed(17'(MID_OB));
      if (sum[i] < 0) begin
        clamp[i] = '0;
      end else if (sum[i] > $signed(17'(DAC_MAX))) begin
        clamp[i] = DAC_MAX;
      end else begin
        clamp[i] = sum[i][DAC_W-1:0];
      end
      da_d[i] = strobe ? clamp[i] : da_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q   <= '0;
      da_clk_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        d_q[i]  <= '0;
        p_q[i]  <= '0;
        da_q[i] <= MID_OB;
      end
    end else begin
      scnt_q   <= scnt_d;
      da_clk_q <= da_clk_d;
      for (int i = 0; i < 2; i++) begin
        d_q[i]  <= d_d[i];
        p_q[i]  <= p_d[i];
        da_q[i] <= da_d[i];
      end
    end
  end

`ifdef DAC_TWOS_COMP_EN
  assign DA_A = ob_to_tc(da_q[0]);
  assign DA_B = ob_to_tc(da_q[1]);
`else
  assign DA_A = da_q[0];
  assign DA_B = da_q[1];
`endif
  assign DA_CLK = da_clk_q;

endmodule

// File: tb/tb_dac_out_drv.sv
// Directed bench for dac_out_drv: reset, fades, reversal, unity passthrough and DAC timing.
module tb_dac_out_drv;

  localparam int unsigned SAMPLE_DIV = 2;
  localparam int unsigned RAMP_DIV   = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [13:0] din_a;
  logic [13:0] din_b;
  logic [13:0] DA_A;
  logic [13:0] DA_B;
  logic        DA_CLK;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int          mscnt = 0;
  bit          mon_en = 0;
  bit          pm_en = 0;
  int          clk_mism = 0;
  int          tviol = 0;
  int          pass_mism = 0;
  logic [13:0] prev_a, prev_b;
  logic [13:0] m_s1, m_s2, exp_a;

  dac_out_drv #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .RAMP_DIV   (RAMP_DIV),
    .GAIN_W     (8),
    .MIDSCALE   (8192)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .din_a  (din_a),
    .din_b  (din_b),
    .DA_A   (DA_A),
    .DA_B   (DA_B),
    .DA_CLK (DA_CLK),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Maps between offset-binary and the code the DUT emits in this build (self-inverse).
  function automatic logic [13:0] dac_code(input logic [13:0] v);
`ifdef DAC_TWOS_COMP_EN
    return {~v[13], v[12:0]};
`else
    return v;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    int sb;
    sb = mscnt;
    @(posedge clk);
    #1;
    if (!rst_n) mscnt = 0;
    else mscnt = (mscnt + 1) % SAMPLE_DIV;
    if (mon_en && rst_n) begin
      if (DA_CLK !== (sb >= SAMPLE_DIV / 2)) clk_mism++;
      if ((DA_A !== prev_a || DA_B !== prev_b) && (DA_CLK !== 1'b0 || sb != 0)) tviol++;
    end
    prev_a = DA_A;
    prev_b = DA_B;
    if (pm_en) begin
      if (sb == 0) exp_a = m_s2;
      m_s2 = m_s1;
      m_s1 = din_a;
      if (dac_code(DA_A) !== exp_a) pass_mism++;
    end
  endtask

  initial begin
    int          cnt;
    logic [13:0] peak;
    logic [13:0] last;
    int          mono;

    rst_n = 1'b0;
    en    = 1'b0;
    din_a = 14'd1234;
    din_b = 14'd5000;
    repeat (3) step();
    check_eq("rst_da_a", DA_A, dac_code(14'd8192));
    check_eq("rst_da_b", DA_B, dac_code(14'd8192));
    check_eq("rst_da_clk", DA_CLK, 0);
    check_eq("rst_busy", busy, 0);

    // Release: DA_CLK runs 0,1,0,1,... one cycle after the counter starts.
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (6) step();
    check_eq("release_da_clk_pattern", clk_mism, 0);
    check_eq("release_idle_busy", busy, 0);

    // Fade in to unity: 256 steps of 4 cycles each.
    din_a = 14'd16383;
    din_b = 14'd0;
    en    = 1'b1;
    step();
    check_eq("fadein_busy_rise", busy, 1);
    cnt  = 1;
    mono = 0;
    last = dac_code(DA_A);
    for (int n = 0; n < 2000 && busy; n++) begin
      step();
      if (busy) cnt++;
      if (dac_code(DA_A) < last) mono++;
      last = dac_code(DA_A);
    end
    check_eq("fadein_busy_cycles", cnt, 1024);
    check_eq("fadein_monotonic", mono, 0);
    repeat (4) step();
    check_eq("fadein_final_a", DA_A, dac_code(14'd16383));
    check_eq("fadein_final_b", DA_B, dac_code(14'd0));

    // Unity passthrough against a two-stage delay model.
    din_a = 14'd0;
    din_b = 14'd100;
    repeat (6) step();
    m_s1  = 14'd0;
    m_s2  = 14'd0;
    exp_a = 14'd0;
    pm_en = 1'b1;
    for (int i = 1; i < 16384; i++) begin
      din_a = 14'(i);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      din_a = 14'($urandom_range(0, 16383));
      step();
    end
    pm_en = 1'b0;
    check_eq("pass_a_mismatches", pass_mism, 0);
    check_eq("pass_b_exact", DA_B, dac_code(14'd100));
    check_eq("timing_violations", tviol, 0);
    check_eq("da_clk_mismatches", clk_mism, 0);
    check_eq("run_busy", busy, 0);
    step();
    check_eq("ob_tc_zero", DA_B, dac_code(14'd100));

    // Full fade out from unity.
    din_a = 14'd16383;
    repeat (4) step();
    en = 1'b0;
    cnt = 0;
    for (int n = 0; n < 2000; n++) begin
      step();
      if (!busy) break;
      cnt++;
    end
    check_eq("fadeout_busy_cycles", cnt, 1024);
    repeat (4) step();
    check_eq("fadeout_final_a", DA_A, dac_code(14'd8192));

    // Reversal at gain 100: DA peaks at 8192 + (8191*100 >> 8) = 11391.
    en = 1'b1;
    step();
    cnt  = 1;
    peak = dac_code(DA_A);
    repeat (400) begin
      step();
      if (busy) cnt++;
      if (dac_code(DA_A) > peak) peak = dac_code(DA_A);
    end
    en = 1'b0;
    for (int n = 0; n < 2000 && busy; n++) begin
      step();
      if (busy) cnt++;
      if (dac_code(DA_A) > peak) peak = dac_code(DA_A);
    end
    check_eq("reversal_peak", peak, 14'd11391);
    check_eq("reversal_busy_cycles", cnt, 801);
    repeat (4) step();
    check_eq("reversal_final_a", DA_A, dac_code(14'd8192));

    // One-cycle enable pulse: FADE_IN, then FADE_OUT until the first floored step.
    en = 1'b1;
    step();
    cnt = busy ? 1 : 0;
    en  = 1'b0;
    for (int n = 0; n < 50 && busy; n++) begin
      step();
      if (busy) cnt++;
    end
    check_eq("pulse_busy_cycles", cnt, 5);

    // Asynchronous reset in the middle of a fade.
    en = 1'b1;
    repeat (300) step();
    check_eq("midfade_busy", busy, 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_eq("midfade_rst_a", DA_A, dac_code(14'd8192));
    check_eq("midfade_rst_busy", busy, 0);
    check_eq("midfade_rst_da_clk", DA_CLK, 0);
    en = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (8) step();
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_a", DA_A, dac_code(14'd8192));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
